// File: rtl/multi_cycle_control_unit_if.sv
// Bus handshake between the control unit and a load/store slave.
interface multi_cycle_control_unit_if;
   logic busReq;
   logic busWe;
   logic busReady;
   logic busErr;

   modport master (output busReq, output busWe, output busErr, input busReady);
   modport slave  (input busReq, input busWe, input busErr, output busReady);
endinterface

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RV32I control FSM (R/I/L/S/B) with a bus req/ready handshake and timeout abort.
module multi_cycle_control_unit #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [31:0]                   instrCode,
   multi_cycle_control_unit_if.master    bus,
   output logic                          regFileWe,
   output logic [3:0]                    aluControl,
   output logic                          aluSrcMuxSel,
   output logic                          RFWDSrcMuxSel,
   output logic                          branch,
   output logic                          pcEn,
   output logic                          illegal,
   output logic                          retire
);

   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;
   localparam logic [6:0] OP_L = 7'b0000011;
   localparam logic [6:0] OP_S = 7'b0100011;
   localparam logic [6:0] OP_B = 7'b1100011;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

   typedef enum logic [3:0] {
      FETCH, DECODE, R_EXE, I_EXE, B_EXE, L_EXE, L_MEM, L_WB, S_EXE, S_MEM
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;

   logic [6:0] opcode;
   logic [2:0] func3;
   logic       legal;
   logic       tmo;
   logic [3:0] alu_r, alu_i, alu_b;
   logic       unused_instr;

   assign opcode       = instrCode[6:0];
   assign func3        = instrCode[14:12];
   assign legal        = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_L) ||
                         (opcode == OP_S) || (opcode == OP_B);
   assign alu_r        = {instrCode[30], func3};
   assign alu_i        = {instrCode[30] & (func3 == 3'b101), func3};
   assign alu_b        = {1'b0, func3};
   assign unused_instr = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

   // Last permitted wait cycle with no ready: a simultaneous ready always wins.
   assign tmo = (TIMEOUT != 0) && (cnt == TO_LAST) && !bus.busReady;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= FETCH;
         cnt   <= '0;
      end else begin
         case (state)
            FETCH:  state <= DECODE;
            DECODE: begin
               case (opcode)
                  OP_R:    state <= R_EXE;
                  OP_I:    state <= I_EXE;
                  OP_L:    state <= L_EXE;
                  OP_S:    state <= S_EXE;
                  OP_B:    state <= B_EXE;
                  default: state <= FETCH;
               endcase
            end
            L_EXE: begin
               state <= L_MEM;
               cnt   <= '0;
            end
            S_EXE: begin
               state <= S_MEM;
               cnt   <= '0;
            end
            L_MEM: begin
               if (bus.busReady)  state <= L_WB;
               else if (tmo)      state <= FETCH;
               else               cnt   <= cnt + 1'b1;
            end
            S_MEM: begin
               if (bus.busReady || tmo) state <= FETCH;
               else                     cnt   <= cnt + 1'b1;
            end
            default: state <= FETCH;
         endcase
      end
   end

   always_comb begin
      regFileWe     = 1'b0;
      aluControl    = 4'b0000;
      aluSrcMuxSel  = 1'b0;
      RFWDSrcMuxSel = 1'b0;
      branch        = 1'b0;
      pcEn          = 1'b0;
      illegal       = 1'b0;
      retire        = 1'b0;
      bus.busReq    = 1'b0;
      bus.busWe     = 1'b0;
      bus.busErr    = 1'b0;
      case (state)
         DECODE: if (!legal) begin
            illegal = 1'b1;
            pcEn    = 1'b1;
            retire  = 1'b1;
         end
         R_EXE: begin
            regFileWe  = 1'b1;
            aluControl = alu_r;
            pcEn       = 1'b1;
            retire     = 1'b1;
         end
         I_EXE: begin
            regFileWe    = 1'b1;
            aluControl   = alu_i;
            aluSrcMuxSel = 1'b1;
            pcEn         = 1'b1;
            retire       = 1'b1;
         end
         B_EXE: begin
            aluControl = alu_b;
            branch     = 1'b1;
            pcEn       = 1'b1;
            retire     = 1'b1;
         end
         L_EXE, S_EXE: aluSrcMuxSel = 1'b1;
         L_MEM: begin
            aluSrcMuxSel = 1'b1;
            bus.busReq   = 1'b1;
            bus.busErr   = tmo;
            pcEn         = tmo;
            retire       = tmo;
         end
         S_MEM: begin
            aluSrcMuxSel = 1'b1;
            bus.busReq   = 1'b1;
            bus.busWe    = 1'b1;
            bus.busErr   = tmo;
            pcEn         = bus.busReady | tmo;
            retire       = bus.busReady | tmo;
         end
         L_WB: begin
            aluSrcMuxSel  = 1'b1;
            RFWDSrcMuxSel = 1'b1;
            regFileWe     = 1'b1;
            pcEn          = 1'b1;
            retire        = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
